// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential req/ack fetches into a {PC, IR} FIFO, flushed on jump/branch.
// Optional PREFETCH_STATS_EN adds saturating redirect_cnt/drop_cnt outputs.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump,
  input  logic [31:0]              jump_addr,
  input  logic                     branch,
  input  logic [31:0]              branch_addr,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     deq,
  output logic                     valid,
  output logic [31:0]              PC,
  output logic [31:0]              IR,
  output logic [$clog2(DEPTH):0]   count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]              redirect_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d, addr_q, addr_d, pc_q, pc_d, ir_q, ir_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, count_nf_s;
  logic          req_q, req_d, valid_q, valid_d;
  logic [31:0]   mem_pc_q [DEPTH];
  logic [31:0]   mem_ir_q [DEPTH];
  logic          redirect_s, ack_s, push_s, pop_s;
  logic [31:0]   target_s;

  // Next-state logic for fetch FSM, FIFO bookkeeping and the registered head read
  always_comb begin
    redirect_s = jump | branch;
    target_s   = branch ? (branch_addr & 32'hFFFF_FFFC) : (jump_addr & 32'hFFFF_FFFC);
    ack_s      = imem_ack & req_q;
    pop_s      = deq & (count_q != {CW{1'b0}});
    push_s     = (state_q == REQ) & ack_s & ~redirect_s;
    count_nf_s = count_q + CW'(push_s) - CW'(pop_s);
    state_d    = state_q;
    addr_d     = addr_q;

    if (redirect_s) begin
      count_d = {CW{1'b0}};
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      fpc_d   = target_s;
    end else begin
      count_d = count_nf_s;
      head_d  = head_q + PW'(pop_s);
      tail_d  = tail_q + PW'(push_s);
      fpc_d   = push_s ? (fpc_q + 32'd4) : fpc_q;
    end

    case (state_q)
      IDLE: begin
        if (!redirect_s && (count_q < DEPTH_C)) begin
          state_d = REQ;
          addr_d  = fpc_q;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (push_s) begin
          // Back-to-back only if the pushed entry (net of a same-cycle pop) still leaves room
          if (count_nf_s < DEPTH_C) begin
            state_d = REQ;
            addr_d  = fpc_q + 32'd4;
          end else begin
            state_d = IDLE;
          end
        end else if (ack_s) begin
          state_d = IDLE;
        end else if (redirect_s) begin
          state_d = DROP;
        end else begin
          state_d = REQ;
        end
      end
      DROP: begin
        if (ack_s) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d   = (state_d != IDLE);
    valid_d = (count_d != {CW{1'b0}});
    if (!valid_d) begin
      pc_d = 32'h0;
      ir_d = 32'h0;
    end else if (push_s && (tail_q == head_d)) begin
      pc_d = addr_q;
      ir_d = imem_rdata;
    end else begin
      pc_d = mem_pc_q[head_d];
      ir_d = mem_ir_q[head_d];
    end
  end

  // State, FIFO storage and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= 32'h0;
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      ir_q    <= 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i] <= 32'h0;
        mem_ir_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      if (push_s) begin
        mem_pc_q[tail_q] <= addr_q;
        mem_ir_q[tail_q] <= imem_rdata;
      end
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign valid     = valid_q;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign count     = count_q;

`ifdef PREFETCH_STATS_EN
  logic [15:0] redirect_cnt_q, redirect_cnt_d, drop_cnt_q, drop_cnt_d;
  logic        drop_s;

  // Saturating statistics counters
  always_comb begin
    drop_s = ack_s & ((state_q == DROP) | ((state_q == REQ) & redirect_s));
    if (redirect_s && (redirect_cnt_q != 16'hFFFF)) begin
      redirect_cnt_d = redirect_cnt_q + 16'd1;
    end else begin
      redirect_cnt_d = redirect_cnt_q;
    end
    if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= 16'h0;
      drop_cnt_q     <= 16'h0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign drop_cnt     = drop_cnt_q;
`endif

endmodule
